// File: rtl/program_loader.sv
// Streams a length-prefixed program into the CPU's program store, zero-fills the tail, and
// gates cpu_run until a load validates. Optional checksum byte: define PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_run
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [8:0]      DEPTH9  = 9'(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_FILL,
    S_DONE,
    S_ERROR
  } state_t;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  state_t          state;
  wr_req_t         wr;
  // One extra bit so a full-depth program does not wrap the counter back to 0.
  logic [ADDR_W:0] cnt;
  logic [ADDR_W:0] len;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]      csum;
`endif
  logic            accept;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      wr    <= '0;
      cnt   <= '0;
      len   <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum  <= '0;
`endif
    end else begin
      wr.en <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state <= S_LEN;
            cnt   <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum  <= '0;
`endif
          end
        end
        S_LEN: begin
          if (accept) begin
            if (in_data == 8'd0 || {1'b0, in_data} > DEPTH9) begin
              state <= S_ERROR;
            end else begin
              len   <= in_data[ADDR_W:0];
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            wr.en   <= 1'b1;
            wr.addr <= cnt[ADDR_W-1:0];
            wr.data <= DATA_W'(in_data);
            cnt     <= cnt + ONE;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum    <= csum + in_data;
            if (cnt + ONE == len) state <= S_CSUM;
`else
            if (cnt + ONE == len) state <= (len == DEPTH_C) ? S_DONE : S_FILL;
`endif
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (accept) begin
            if (in_data != csum) begin
              state <= S_ERROR;
            end else if (len == DEPTH_C) begin
              state <= S_DONE;
            end else begin
              // First fill write goes out alongside the checksum acceptance.
              wr.en   <= 1'b1;
              wr.addr <= cnt[ADDR_W-1:0];
              wr.data <= '0;
              cnt     <= cnt + ONE;
              state   <= S_FILL;
            end
          end
        end
`endif
        S_FILL: begin
          if (cnt == DEPTH_C) begin
            state <= S_DONE;
          end else begin
            wr.en   <= 1'b1;
            wr.addr <= cnt[ADDR_W-1:0];
            wr.data <= '0;
            cnt     <= cnt + ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state)
      S_LEN, S_DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
`endif
      S_FILL:  busy = 1'b1;
      default: ;
    endcase
  end

  assign done    = (state == S_DONE);
  assign cpu_run = (state == S_DONE);
  assign error   = (state == S_ERROR);
  assign wr_en   = wr.en;
  assign wr_addr = wr.addr;
  assign wr_data = wr.data;

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader; expected writes and status events are
// queued by the stimulus and checked by an independent negedge monitor.
module tb_program_loader;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready, wr_en, busy, done, error, cpu_run;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  program_loader #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error), .cpu_run(cpu_run)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int addr; int data; } wr_t;
  typedef struct { int cyc; bit pre; logic [4:0] flags; } st_t;  // {busy,done,error,cpu_run,in_ready}

  wr_t        wq[$];
  st_t        sq[$];
  logic [7:0] payload[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every write and status event must land on the cycle the model predicts.
  always @(negedge clk) begin
    if (!reset) begin
      while (wq.size() > 0 && wq[0].cyc < cyc) begin
        n_cmp++; n_err++;
        $display("FAIL missed_write: got none want addr %0h data %0h at cyc %0d", wq[0].addr, wq[0].data, wq[0].cyc);
        void'(wq.pop_front());
      end
      if (wr_en) begin
        if (wq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_write: got addr %0h data %0h want no write (cyc %0d)", wr_addr, wr_data, cyc);
        end else begin
          wr_t w;
          w = wq.pop_front();
          chk("write_addr", int'(wr_addr), w.addr);
          chk("write_data", int'(wr_data), w.data);
          chk("write_cycle", cyc, w.cyc);
        end
      end
      while (sq.size() > 0 && sq[0].cyc <= cyc) begin
        st_t s;
        s = sq.pop_front();
        if (s.cyc < cyc) begin
          n_cmp++; n_err++;
          $display("FAIL missed_status: got none want check at cyc %0d", s.cyc);
        end else if (s.pre) begin
          chk("status_before_end", int'({busy, done, error, cpu_run}), int'(s.flags[4:1]));
        end else begin
          chk("status_end", int'({busy, done, error, cpu_run, in_ready}), int'(s.flags));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b, output int t);
    int g = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && g < 20) begin @(negedge clk); g++; end
    if (!in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL in_ready_timeout: got 0 want 1 (cyc %0d)", cyc);
      in_valid = 1'b0;
      t = cyc;
      return;
    end
    @(posedge clk); #1;
    t = cyc;
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", int'(busy), 1);
    chk("start_in_ready", int'(in_ready), 1);
    chk("start_done_clr", int'(done), 0);
    chk("start_error_clr", int'(error), 0);
  endtask

  task automatic drain();
    int g = 0;
    while ((wq.size() > 0 || sq.size() > 0) && g < 200) begin @(posedge clk); #1; g++; end
    if (wq.size() > 0 || sq.size() > 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: got %0d pending want 0", wq.size() + sq.size());
      wq.delete();
      sq.delete();
    end
  endtask

  // Reference: program bytes land at 0..L-1 in order, zeros at L..DEPTH-1, then DONE.
  task automatic run_load(input int lenb, input bit bad_cs, input int maxgap);
    int         t, te, L;
    logic [7:0] sum, b;
    logic [4:0] fin;
    do_start();
    send(lenb[7:0], t);
    if (lenb == 0 || lenb > DEPTH) begin
      sq.push_back('{t, 1'b0, 5'b00100});
      drain();
      payload.delete();
      return;
    end
    L = lenb;
    sum = 8'd0;
    for (int k = 0; k < L; k++) begin
      b = (k < payload.size()) ? payload[k] : 8'($urandom);
      if (k > 0 && maxgap > 0) idle($urandom_range(0, maxgap));
      send(b, t);
      wq.push_back('{t, k, int'(b)});
      sum = sum + b;
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send(bad_cs ? sum + 8'd1 : sum, t);
    if (bad_cs) begin
      te  = t;
      fin = 5'b00100;
    end else begin
      for (int i = 0; i < DEPTH - L; i++) wq.push_back('{t + i, L + i, 0});
      te  = t + (DEPTH - L);
      fin = 5'b01010;
    end
`else
    for (int i = 0; i < DEPTH - L; i++) wq.push_back('{t + 1 + i, L + i, 0});
    te  = (L < DEPTH) ? t + (DEPTH - L) + 1 : t;
    fin = 5'b01010;
    if (bad_cs) fin = 5'b01010;
`endif
    if (te > t) sq.push_back('{te - 1, 1'b1, 5'b10000});
    sq.push_back('{te, 1'b0, fin});
    drain();
    payload.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 0);
    chk({tag, "_wr_en"},    int'(wr_en),    0);
    chk({tag, "_wr_addr"},  int'(wr_addr),  0);
    chk({tag, "_wr_data"},  int'(wr_data),  0);
    chk({tag, "_busy"},     int'(busy),     0);
    chk({tag, "_done"},     int'(done),     0);
    chk({tag, "_error"},    int'(error),    0);
    chk({tag, "_cpu_run"},  int'(cpu_run),  0);
  endtask

  initial begin
    int         t, lenb;
    logic [7:0] b0, b1;
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    idle(2);
    chk_reset_outputs("reset");
    reset = 1'b0;
    idle(2);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    payload = '{8'h00, 8'h01, 8'h21};
    run_load(3, 1'b0, 0);
    payload = '{8'h00, 8'h01, 8'h21};
    run_load(3, 1'b1, 0);
    chk("error_held", int'(error), 1);
`else
    payload = '{8'h71, 8'h12};
    run_load(2, 1'b0, 0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    idle(3);
    chk("no_extra_byte", int'(in_ready), 0);
    in_valid = 1'b0;
`endif

    run_load(0, 1'b0, 0);
    run_load(17, 1'b0, 0);
    run_load(16, 1'b0, 0);
    chk("full_done", int'(done), 1);

    // Stalled load interrupted by reset; a start pulse mid-load must be ignored.
    do_start();
    send(8'd4, t);
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    send(b0, t);
    wq.push_back('{t, 0, int'(b0)});
    start = 1'b1;
    idle(1);
    start = 1'b0;
    idle(2);
    send(b1, t);
    wq.push_back('{t, 1, int'(b1)});
    idle(3);
    chk("stall_busy", int'(busy), 1);
    reset = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    wq.delete();
    idle(1);
    run_load(4, 1'b0, 3);

    for (int n = 0; n < 20; n++) begin
      case ($urandom_range(0, 9))
        0:       lenb = 0;
        1:       lenb = $urandom_range(17, 255);
        default: lenb = $urandom_range(1, 16);
      endcase
      run_load(lenb, ($urandom_range(0, 4) == 0), $urandom_range(0, 2));
    end

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
